csr_reg_master: RTL and testbench
=================================

// Module: csr_reg_master
// PURPOSE
// - Register-bus initiator that programs and polls the STRELA CSR block over reg_req_t/reg_rsp_t.
// - Accepts read/write commands on a valid/ready command port and buffers them in a FIFO.
// - Issues the commands one at a time on the register bus and returns one response per command.
// - Sits between a host-side sequencer (DMA or local controller) and the CGRA csr slave.
// PARAMETERS
// - FIFO_DEPTH      4     command FIFO entries; power of two, >=2
// - TIMEOUT_CYCLES  1024  REQ-state cycles before abort (used only with CSR_MASTER_TIMEOUT_EN)
// PORTS
// - clk_i        in   1          clock
// - rst_ni       in   1          asynchronous active-low reset
// - cmd_valid_i  in   1          command valid
// - cmd_ready_o  out  1          command accepted when valid&ready
// - cmd_write_i  in   1          1=write, 0=read
// - cmd_addr_i   in   32         register byte address
// - cmd_wdata_i  in   32         write data (ignored for reads)
// - rsp_valid_o  out  1          response valid
// - rsp_ready_i  in   1          response consumed
// - rsp_rdata_o  out  32         read data; 0 for writes
// - rsp_error_o  out  1          bus error or timeout
// - reg_req_o    out  reg_req_t  register-bus request (addr, write, wdata, wstrb, valid)
// - reg_rsp_i    in   reg_rsp_t  register-bus response (rdata, error, ready)
// - busy_o       out  1          FIFO non-empty or FSM not IDLE
// BEHAVIOUR
// - Reset: FIFO empty; FSM=IDLE; reg_req_o all zero; rsp_valid_o=0; rsp_rdata_o=0; rsp_error_o=0; busy_o=0.
// - cmd_ready_o = !fifo_full; no bypass. A command pushed in cycle N is visible to the FSM in N+1.
// - FSM IDLE: if FIFO non-empty, pop into cmd register, go REQ next cycle.
// - FSM REQ: reg_req_o.valid=1, addr/write/wdata from cmd register, wstrb=4'hF.
//   - Request fields stay stable until reg_rsp_i.ready=1.
//   - On ready: capture rdata (forced 0 for writes) and error; go RSP.
// - FSM RSP: rsp_valid_o=1, data stable until rsp_ready_i=1, then IDLE.
// - Latency with an always-ready responder and rsp_ready_i=1:
//   - accept at N, pop at N+1, reg valid at N+2, rsp_valid_o at N+3.
//   - Back-to-back throughput is one command per 3 cycles.
// - Strictly in-order; one outstanding bus transaction; never more than one pending response.
// - FIFO full: cmd_ready_o=0. Push and pop in the same cycle are both honoured; count unchanged.
// - Response backpressure: FSM holds in RSP; FIFO keeps accepting until full.
// - reg_rsp_i.ready while not in REQ is ignored.
// - Reset mid-transaction: reg_req_o.valid drops asynchronously; queued commands are discarded.
// CONFIGURATION
// - CSR_MASTER_TIMEOUT_EN defined:
//   - A 32-bit counter clears on REQ entry and increments each REQ cycle without ready.
//   - When it reaches TIMEOUT_CYCLES: drop valid, go RSP with rsp_error_o=1, rsp_rdata_o=0.
// - CSR_MASTER_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
// - cgra_pkg holds:
//   - csr_cmd_t struct {write, addr[31:0], wdata[31:0]}
//   - csr_master_state_e enum {IDLE, REQ, RSP}
//   - CSR_MASTER_FIFO_DEPTH default
// - Sub-module csr_cmd_fifo: synchronous FIFO of csr_cmd_t with push/pop/full/empty, async reset.
// TESTING
// - Write CONFIG_ADDR_ADDR=0x8000_0000 to a csr instance -> config_addr_o=0x8000_0000; rsp rdata=0, error=0.
// - Read CTR_EXEC_REG_ADDR with exec_cycles_i=0x1234 -> rsp_rdata_o=0x1234; rsp_valid_o 3 cycles after accept.
// - Push 5 commands, FIFO_DEPTH=4, rsp_ready_i=0 -> cmd_ready_o low after 5th accept; drain gives 5 responses in order.
// - Responder holds ready=0 for 7 cycles -> req fields stable 8 cycles; response follows; reg_rsp_i.error=1 gives rsp_error_o=1.
// - With CSR_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready never asserted -> valid drops after 16 cycles; error=1, rdata=0.
// - Assert rst_ni low mid-REQ with 3 queued -> reg_req_o.valid=0 immediately; after release busy_o=0, no responses.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared types for the CGRA CSR register-bus initiator.
package cgra_pkg;

    localparam int unsigned CSR_MASTER_FIFO_DEPTH = 4;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } csr_cmd_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } csr_master_state_e;

endpackage

// File: rtl/csr_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module csr_cmd_fifo
    import cgra_pkg::*;
#(
    parameter int unsigned DEPTH = CSR_MASTER_FIFO_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  csr_cmd_t data_i,
    input  logic     pop_i,
    output csr_cmd_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    csr_cmd_t   mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/csr_reg_master.sv
// Register-bus initiator: queues CSR commands and issues them one at a time.
// Optional REQ-phase abort is enabled by defining CSR_MASTER_TIMEOUT_EN.
module csr_reg_master
    import cgra_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = CSR_MASTER_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        busy_o
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("csr_reg_master: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
        $error("csr_reg_master: TIMEOUT_CYCLES must be nonzero");
    end

    csr_master_state_e state_q, state_d;
    csr_cmd_t          cmd_q, cmd_d;
    csr_cmd_t          fifo_in;
    csr_cmd_t          fifo_data;
    logic [31:0]       rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              timeout_hit;

    assign fifo_in     = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign cmd_ready_o = !fifo_full;
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
    assign busy_o      = !fifo_empty || (state_q != IDLE);

    csr_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CSR_MASTER_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Hit on the last allowed REQ cycle so valid is high for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 1);

    // Wait counter: held at zero outside REQ, so it starts from zero on every REQ entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q != REQ) begin
            tmo_cnt_q <= '0;
        end else if (!reg_rsp_i.ready) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State, command and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Next-state and bus/response outputs; request fields are driven only in REQ.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        fifo_pop    = 1'b0;
        reg_req_o   = '0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_data;
                    state_d  = REQ;
                end
            end
            REQ: begin
                reg_req_o.addr  = cmd_q.addr;
                reg_req_o.write = cmd_q.write;
                reg_req_o.wdata = cmd_q.wdata;
                reg_req_o.wstrb = 4'hF;
                reg_req_o.valid = 1'b1;
                if (reg_rsp_i.ready) begin
                    rdata_d = cmd_q.write ? '0 : reg_rsp_i.rdata;
                    error_d = reg_rsp_i.error;
                    state_d = RSP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_reg_master.sv
// Directed bench for csr_reg_master with a small CSR responder model.
module tb_csr_reg_master;
    import cgra_pkg::*;

    localparam logic [31:0] CONFIG_ADDR_ADDR  = 32'h0000_0008;
    localparam logic [31:0] CTR_EXEC_REG_ADDR = 32'h0000_0020;
    localparam logic [31:0] RD_PATTERN        = 32'h5A5A_0000;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    reg_req_t    reg_req;
    reg_rsp_t    reg_rsp;
    logic        busy;

    // Responder controls and state.
    int unsigned rsp_wait;
    logic        rsp_err;
    logic        rsp_hang;
    int unsigned wait_cnt;
    logic [31:0] config_addr;
    logic [31:0] exec_cycles;

    int unsigned checks;
    int unsigned errors;

    csr_reg_master #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .reg_req_o   (reg_req),
        .reg_rsp_i   (reg_rsp),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: ready after rsp_wait stalled cycles, read data depends on address.
    always_comb begin
        reg_rsp       = '0;
        reg_rsp.ready = reg_req.valid && !rsp_hang && (wait_cnt >= rsp_wait);
        reg_rsp.error = rsp_err;
        if (reg_req.addr == CTR_EXEC_REG_ADDR)      reg_rsp.rdata = exec_cycles;
        else if (reg_req.addr == CONFIG_ADDR_ADDR)  reg_rsp.rdata = config_addr;
        else                                        reg_rsp.rdata = reg_req.addr ^ RD_PATTERN;
    end

    always @(posedge clk) begin
        if (!rst_n || !reg_req.valid || reg_rsp.ready) wait_cnt <= 0;
        else                                          wait_cnt <= wait_cnt + 1;
        if (reg_req.valid && reg_rsp.ready && reg_req.write && reg_req.addr == CONFIG_ADDR_ADDR)
            config_addr <= reg_req.wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int unsigned n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req_valid();
        int unsigned n;
        n = 0;
        while (!reg_req.valid && n < 20) begin
            step();
            n++;
        end
        check("req_arrives", 32'(reg_req.valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q [5];
        int unsigned lat;
        int unsigned vcnt;
        int unsigned got;
        int unsigned stray;

        checks = 0; errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; rsp_wait = 0; rsp_err = 1'b0; rsp_hang = 1'b0;
        config_addr = '0; exec_cycles = 32'h0000_1234;
        repeat (3) step();

        // Reset state.
        check("rst_req", 32'(reg_req.valid), 32'd0);
        check("rst_req_addr", reg_req.addr, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_error", 32'(rsp_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Write CONFIG_ADDR: pop cycle, request cycle, response cycle.
        push_cmd(1'b1, CONFIG_ADDR_ADDR, 32'h8000_0000);
        check("wr_pop_no_req", 32'(reg_req.valid), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        step();
        check("wr_req_valid", 32'(reg_req.valid), 32'd1);
        check("wr_req_addr", reg_req.addr, CONFIG_ADDR_ADDR);
        check("wr_req_wdata", reg_req.wdata, 32'h8000_0000);
        check("wr_req_write", 32'(reg_req.write), 32'd1);
        check("wr_req_wstrb", 32'(reg_req.wstrb), 32'hF);
        step();
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_rsp_error", 32'(rsp_error), 32'd0);
        check("wr_config_addr", config_addr, 32'h8000_0000);
        step();
        check("wr_idle_busy", 32'(busy), 32'd0);

        // Read CTR_EXEC: response three cycles after accept.
        push_cmd(1'b0, CTR_EXEC_REG_ADDR, 32'hFFFF_FFFF);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check("rd_latency", lat, 32'd3);
        check("rd_rdata", rsp_rdata, 32'h0000_1234);
        check("rd_error", 32'(rsp_error), 32'd0);
        step();

        // Five commands under response backpressure, then drain in order.
        rsp_ready = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            exp_q[k] = (32'h100 + 32'(4 * k)) ^ RD_PATTERN;
            push_cmd(1'b0, 32'h100 + 32'(4 * k), 32'h0);
        end
        check("bp_full", 32'(cmd_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        got = 0;
        for (int unsigned c = 0; c < 60; c++) begin
            if (rsp_valid) begin
                if (got < 5) check("bp_order", rsp_rdata, exp_q[got]);
                got++;
            end
            step();
        end
        check("bp_count", got, 32'd5);
        check("bp_drained_busy", 32'(busy), 32'd0);

        // Responder stalls 7 cycles and flags an error.
        rsp_wait = 7;
        rsp_err  = 1'b1;
        push_cmd(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        wait_req_valid();
        vcnt = 0;
        while (reg_req.valid && vcnt < 30) begin
            check("stall_addr", reg_req.addr, 32'h0000_0044);
            check("stall_wdata", reg_req.wdata, 32'hDEAD_BEEF);
            step();
            vcnt++;
        end
        check("stall_cycles", vcnt, 32'd8);
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall_rsp_error", 32'(rsp_error), 32'd1);
        check("stall_rsp_rdata", rsp_rdata, 32'd0);
        step();
        rsp_wait = 0;
        rsp_err  = 1'b0;

        // Responder never answers.
        rsp_hang = 1'b1;
        push_cmd(1'b0, 32'h0000_0200, 32'h0);
        wait_req_valid();
        vcnt = 0;
        while (reg_req.valid && vcnt < 40) begin
            step();
            vcnt++;
        end
`ifdef CSR_MASTER_TIMEOUT_EN
        check("tmo_cycles", vcnt, 32'd16);
        check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_rsp_error", 32'(rsp_error), 32'd1);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        step();
`else
        check("hang_cycles", vcnt, 32'd40);
        check("hang_addr", reg_req.addr, 32'h0000_0200);
`endif

        // Reset in the middle of REQ with commands queued.
        push_cmd(1'b0, 32'h0000_0300, 32'h0);
        for (int unsigned k = 1; k < 4; k++) push_cmd(1'b0, 32'h300 + 32'(4 * k), 32'h0);
        check("mid_req_valid", 32'(reg_req.valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(reg_req.valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        rsp_hang = 1'b0;
        stray = 0;
        for (int unsigned c = 0; c < 10; c++) begin
            step();
            if (rsp_valid || reg_req.valid || busy) stray++;
        end
        check("post_rst_quiet", stray, 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
